lsu_mem_ctrl: RTL

Multi-cycle load/store unit that consumes the decoded memory-access controls (MemWrite size code, RegWrite load-size code, sign_for_reg) and executes them against a word-only data memory over a req/ack handshake. Byte and half stores use read-modify-write. Loads are sign- or zero-extended to 32 bits. Sits between the execute stage and data memory. Stalls the core via busy.

---
 rtl/lsu_mem_ctrl.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_ctrl.sv
// Multi-cycle load/store unit: drives a word-only data memory over req/ack,
// does read-modify-write for byte/half stores and extends loaded lanes.
module lsu_mem_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              start,
  input  logic [1:0]        MemWrite,
  input  logic [1:0]        RegWrite,
  input  logic              sign_for_reg,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       WriteData,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       ReadDataOut,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, DONE} state_t;

  state_t            state_reg, state_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic [31:0]       rdout_reg, rdout_next;
  logic              req_reg, req_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] maddr_reg, maddr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [1:0]        lane_reg, lane_next;
  logic [1:0]        size_reg, size_next;
  logic              store_reg, store_next;
  logic              sign_reg, sign_next;
  logic [15:0]       sdata_reg, sdata_next;
  logic [31:0]       word_reg, word_next;

  // Store wins when both sizes are requested.
  logic       acc_store;
  logic [1:0] acc_size;
  logic       misaligned;
  logic       timed_out;
  assign acc_store  = (MemWrite != 2'b00);
  assign acc_size   = acc_store ? MemWrite : RegWrite;
  assign misaligned = ((acc_size == 2'b10) && Addr[0]) ||
                      ((acc_size == 2'b11) && (Addr[1:0] != 2'b00));
  assign timed_out  = (cnt_reg == CNT_W'(TIMEOUT - 1));

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  assign byte_sel = mem_rdata[{lane_reg, 3'b000} +: 8];
  assign half_sel = mem_rdata[{lane_reg[1], 4'b0000} +: 16];

  always_comb begin
    load_ext = mem_rdata;
    case (size_reg)
      2'b01:   load_ext = {{24{sign_reg & byte_sel[7]}}, byte_sel};
      2'b10:   load_ext = {{16{sign_reg & half_sel[15]}}, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  // Each byte lane takes store data when selected, else keeps the read word.
  logic [31:0] merged;
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic hit;
      assign hit = (size_reg == 2'b01) ? (lane_reg == LANE) : (lane_reg[1] == LANE[1]);
      assign merged[8*gi +: 8] = !hit ? word_reg[8*gi +: 8] :
                                 (size_reg == 2'b10) ? sdata_reg[8*(gi%2) +: 8] : sdata_reg[7:0];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    rdout_next = rdout_reg;
    req_next   = req_reg;
    we_next    = we_reg;
    maddr_next = maddr_reg;
    wdata_next = wdata_reg;
    cnt_next   = cnt_reg;
    lane_next  = lane_reg;
    size_next  = size_reg;
    store_next = store_reg;
    sign_next  = sign_reg;
    sdata_next = sdata_reg;
    word_next  = word_reg;
    case (state_reg)
      IDLE: begin
        if (start && ((MemWrite != 2'b00) || (RegWrite != 2'b00))) begin
          lane_next  = Addr[1:0];
          size_next  = acc_size;
          store_next = acc_store;
          sign_next  = sign_for_reg;
          sdata_next = WriteData[15:0];
          maddr_next = {Addr[ADDR_W-1:2], 2'b00};
          cnt_next   = '0;
          if (misaligned) begin
            state_next = DONE;
            done_next  = 1'b1;
            err_next   = 1'b1;
          end else if (acc_store && (acc_size == 2'b11)) begin
            state_next = WRITE;
            busy_next  = 1'b1;
            req_next   = 1'b1;
            we_next    = 1'b1;
            wdata_next = WriteData;
          end else begin
            state_next = READ;
            busy_next  = 1'b1;
            req_next   = 1'b1;
            we_next    = 1'b0;
          end
        end
      end
      READ: begin
        if (mem_ack) begin
          req_next = 1'b0;
          if (store_reg) begin
            word_next  = mem_rdata;
            state_next = MERGE;
          end else begin
            rdout_next = load_ext;
            state_next = DONE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end
        end else if (timed_out) begin
          req_next   = 1'b0;
          state_next = DONE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          err_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      MERGE: begin
        wdata_next = merged;
        state_next = WRITE;
        req_next   = 1'b1;
        we_next    = 1'b1;
        cnt_next   = '0;
      end
      WRITE: begin
        if (mem_ack || timed_out) begin
          req_next   = 1'b0;
          we_next    = 1'b0;
          state_next = DONE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          err_next   = !mem_ack;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
        req_next   = 1'b0;
        we_next    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      rdout_reg <= '0;
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
      maddr_reg <= '0;
      wdata_reg <= '0;
      cnt_reg   <= '0;
      lane_reg  <= '0;
      size_reg  <= '0;
      store_reg <= 1'b0;
      sign_reg  <= 1'b0;
      sdata_reg <= '0;
      word_reg  <= '0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      rdout_reg <= rdout_next;
      req_reg   <= req_next;
      we_reg    <= we_next;
      maddr_reg <= maddr_next;
      wdata_reg <= wdata_next;
      cnt_reg   <= cnt_next;
      lane_reg  <= lane_next;
      size_reg  <= size_next;
      store_reg <= store_next;
      sign_reg  <= sign_next;
      sdata_reg <= sdata_next;
      word_reg  <= word_next;
    end
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign err         = err_reg;
  assign ReadDataOut = rdout_reg;
  assign mem_req     = req_reg;
  assign mem_we      = we_reg;
  assign mem_addr    = maddr_reg;
  assign mem_wdata   = wdata_reg;

endmodule
